// File: rtl/pipeline_types.sv
// pipeline_types: shared duty types and colour-word mapping; LED_PWM_GAMMA_EN selects the gamma curve.
package pipeline_types;
   typedef struct packed {
      logic [7:0] g;
      logic [7:0] r;
      logic [7:0] b;
   } rgb_duty_t;
   typedef enum logic {IDLE, RUN} pwm_state_t;
   localparam logic [7:0] PWM_MAX_COUNT = 8'd254;
`ifdef LED_PWM_GAMMA_EN
   function automatic logic [7:0] duty_map(input logic [7:0] v);
      logic [15:0] p;
      logic [16:0] s;
      p = {8'd0, v} * {8'd0, v};
      s = {1'b0, p} + 17'd255;
      return 8'(s >> 8);
   endfunction
`else
   function automatic logic [7:0] duty_map(input logic [7:0] v);
      return v;
   endfunction
`endif
   function automatic rgb_duty_t word_map(input logic [23:0] w);
      return '{g: duty_map(w[23:16]), r: duty_map(w[15:8]), b: duty_map(w[7:0])};
   endfunction
endpackage

// File: rtl/pwm_channel.sv
// pwm_channel: per-colour duty comparator with a registered drive output.
module pwm_channel (
   input  logic       i_clk,
   input  logic       i_reset_n,
   input  logic       i_run,
   input  logic [7:0] i_count,
   input  logic [7:0] i_duty,
   output logic       o_pwm
);
   always_ff @(posedge i_clk or negedge i_reset_n)
      if (!i_reset_n) o_pwm <= 1'b0;
      else o_pwm <= i_run && (i_count < i_duty);
endmodule

// File: rtl/led_pwm.sv
// led_pwm: three-channel LED PWM with pending/active duty buffering and idle blanking (gamma via LED_PWM_GAMMA_EN).
module led_pwm
   import pipeline_types::*;
#(
   parameter int PRESCALE     = 4,
   parameter int IDLE_PERIODS = 64
) (
   input  logic        i_clk,
   input  logic        i_reset_n,
   input  logic [23:0] i_led_data,
   input  logic        i_data_valid,
   output logic        o_pwm_r,
   output logic        o_pwm_g,
   output logic        o_pwm_b,
   output logic        o_update,
   output logic        o_pending
);
   localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
   localparam int IW = $clog2(IDLE_PERIODS + 1);
   localparam logic [PW-1:0] PRE_LAST  = PW'(PRESCALE - 1);
   localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_PERIODS - 1);

   pwm_state_t    state, state_nxt;
   logic [PW-1:0] pre, pre_nxt;
   logic [7:0]    count, count_nxt;
   logic [IW-1:0] idle_cnt, idle_nxt;
   rgb_duty_t     pend, pend_nxt, act, act_nxt, mapped;
   logic          pending_nxt, update_nxt, tick, wrap;

   assign mapped = word_map(i_led_data);
   assign tick   = pre == PRE_LAST;
   assign wrap   = state == RUN && tick && count == PWM_MAX_COUNT;

   // a strobe landing on the wrap goes straight to active, overriding any pending word
   always_comb begin
      state_nxt   = state;
      pre_nxt     = '0;
      count_nxt   = '0;
      idle_nxt    = '0;
      pend_nxt    = pend;
      act_nxt     = act;
      pending_nxt = o_pending;
      update_nxt  = 1'b0;
      if (state == IDLE) begin
         if (i_data_valid) begin
            state_nxt   = RUN;
            act_nxt     = mapped;
            pending_nxt = 1'b0;
            update_nxt  = 1'b1;
         end
      end else begin
         pre_nxt   = tick ? '0 : pre + 1'b1;
         count_nxt = !tick ? count : wrap ? 8'd0 : count + 1'b1;
         idle_nxt  = i_data_valid ? '0 : wrap ? idle_cnt + 1'b1 : idle_cnt;
         if (wrap && i_data_valid) begin
            act_nxt     = mapped;
            pending_nxt = 1'b0;
            update_nxt  = 1'b1;
         end else if (i_data_valid) begin
            pend_nxt    = mapped;
            pending_nxt = 1'b1;
         end else if (wrap && o_pending) begin
            act_nxt     = pend;
            pending_nxt = 1'b0;
            update_nxt  = 1'b1;
         end
         if (wrap && !i_data_valid && idle_cnt == IDLE_LAST) begin
            state_nxt   = IDLE;
            act_nxt     = '0;
            idle_nxt    = '0;
            pre_nxt     = '0;
            count_nxt   = '0;
            pending_nxt = 1'b0;
            update_nxt  = 1'b0;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n)
      if (!i_reset_n) begin
         state     <= IDLE;
         pre       <= '0;
         count     <= '0;
         idle_cnt  <= '0;
         pend      <= '0;
         act       <= '0;
         o_pending <= 1'b0;
         o_update  <= 1'b0;
      end else begin
         state     <= state_nxt;
         pre       <= pre_nxt;
         count     <= count_nxt;
         idle_cnt  <= idle_nxt;
         pend      <= pend_nxt;
         act       <= act_nxt;
         o_pending <= pending_nxt;
         o_update  <= update_nxt;
      end

   pwm_channel u_g (.i_clk(i_clk), .i_reset_n(i_reset_n), .i_run(state == RUN), .i_count(count), .i_duty(act.g), .o_pwm(o_pwm_g));
   pwm_channel u_r (.i_clk(i_clk), .i_reset_n(i_reset_n), .i_run(state == RUN), .i_count(count), .i_duty(act.r), .o_pwm(o_pwm_r));
   pwm_channel u_b (.i_clk(i_clk), .i_reset_n(i_reset_n), .i_run(state == RUN), .i_count(count), .i_duty(act.b), .o_pwm(o_pwm_b));
endmodule

// File: doc/led_pwm.md
LED_PWM -- requirements
Module: led_pwm

Interface
REQ-001 Parameter PRESCALE, default 4, meaning clock cycles per PWM tick (legal range 1..1024).
REQ-002 Parameter IDLE_PERIODS, default 64, meaning the number of PWM periods without new data before outputs blank.
REQ-003 i_clk  input  1  single clock; all logic is synchronous to its rising edge.
REQ-004 i_reset_n  input  1  reset, asynchronous and active-low.
REQ-005 i_led_data  input  24  colour word from the upstream shift register: G=[23:16], R=[15:8], B=[7:0].
REQ-006 i_data_valid  input  1  one-cycle strobe; i_led_data is valid in this cycle.
REQ-007 o_pwm_r, o_pwm_g, o_pwm_b  output  1 each  registered PWM drive per channel.
REQ-008 o_update  output  1  one-cycle pulse when new duties become active.
REQ-009 o_pending  output  1  high while a captured word awaits the next period boundary.

Function
REQ-010 Prescaler: counts 0..PRESCALE-1; tick asserts in the cycle the prescaler equals PRESCALE-1, then the prescaler returns to 0.
REQ-011 Period counter: 8 bits, advances on tick, counts 0..254 and wraps to 0, giving a period of 255 ticks; wrap = tick AND count==254.
REQ-012 Per channel, drive = (state==RUN) AND (count < active_duty), registered so the output lags count by 1 clock; duty 0 gives constant low and duty 255 gives constant high.
REQ-013 On i_data_valid, load the word into the pending register and set o_pending; if several strobes arrive within one period, the last one wins.
REQ-014 At wrap with o_pending set, copy pending to active, clear o_pending, and pulse o_update in the same cycle; the new duties govern the period starting at count 0.
REQ-015 If i_data_valid coincides with wrap, load i_led_data directly into active, leave o_pending clear, and pulse o_update.
REQ-016 FSM states: IDLE (outputs low, period counter held at 0) and RUN.
REQ-017 IDLE->RUN on the first i_data_valid: active loads immediately, o_update pulses, and count starts at 0 on the next cycle.
REQ-018 RUN->IDLE when IDLE_PERIODS consecutive wraps occur with no i_data_valid; the idle counter clears on every i_data_valid; in the transition cycle, active duties clear to 0.
REQ-019 Active and pending duties are 8 bits unsigned; no arithmetic overflow is permitted.

Reset
REQ-020 While i_reset_n is low: state=IDLE; prescaler, count, idle counter, pending, and active all 0; o_pwm_*, o_update, and o_pending all 0.
REQ-021 Reset asserted mid-period forces outputs low asynchronously; after deassertion the block waits in IDLE for a fresh i_data_valid.

Configuration
REQ-022 Macro LED_PWM_GAMMA_EN: when defined, each 8-bit value v is mapped to duty = (v*v + 255) >> 8 (16-bit product, 17-bit sum) on its way into the pending or active register; endpoints are preserved (0->0, 1->1, 128->64, 255->255).
REQ-023 When LED_PWM_GAMMA_EN is undefined, duty = v (linear) and no multiplier is synthesised.

Structure
REQ-024 The shared package pipeline_types holds rgb_duty_t (packed struct of g, r, b, 8 bits each) and the constant PWM_MAX_COUNT = 254.
REQ-025 One sub-module, pwm_channel (comparator plus output register, with clock and reset), is instantiated three times.
REQ-026 The prescaler, period counter, idle counter, FSM, and pending/active registers reside in led_pwm.

Verification (PRESCALE=1 unless stated)
REQ-027 Reset, then i_data_valid with 0x80_40_00 -> o_update pulses; after 1 clock o_pwm_g is high for 128 ticks, o_pwm_r for 64, o_pwm_b stays low; period is 255 cycles.
REQ-028 In RUN, strobe 0xFF_00_FF mid-period -> o_pending=1, duties unchanged until wrap; at wrap o_update=1, o_pending=0; then g and b are constant high and r is constant low.
REQ-029 Two strobes (0x10_10_10, then 0x20_20_20) in one period -> only 0x20 is applied; one o_update pulse.
REQ-030 Strobe in the exact wrap cycle -> active loads that word, o_pending stays 0, o_update pulses.
REQ-031 IDLE_PERIODS=2, no further strobes -> after the 2nd wrap the state is IDLE and outputs are low; the next strobe restarts at count 0.
REQ-032 LED_PWM_GAMMA_EN defined, PRESCALE=3, word 0x80_01_FF -> g high for 64 ticks (192 cycles), r for 1 tick (3 cycles), b constant high; reset asserted mid-period -> all outputs low within the same cycle.
